// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder slice.
// Pure declarations: no latency, no flow control.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int nout(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/scan_decoder_onehot_decode.sv
// Generalised N-to-2^N one-hot decoder with enable; all-zero when disabled.
// Combinational, zero latency; no flow control.
module onehot_decode
  import scan_decoder_pkg::*;
#(
  parameter  int ADDR_W = 2,
  localparam int NOUT   = nout(ADDR_W)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NOUT-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select: direct address hold or dwell-timed scan (ping-pong with SCAN_BOUNCE_EN).
// One cycle from sampled strobe to out/cur_addr; enable low blanks out and freezes the scan, no backpressure.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter  int ADDR_W  = 2,
  parameter  int DWELL_W = 4,
  localparam int NOUT    = nout(ADDR_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic [ADDR_W-1:0]  address,
  input  logic               load,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NOUT-1:0]    out,
  output logic [ADDR_W-1:0]  cur_addr,
  output logic               busy,
  output logic               wrap
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               wrap_d;
  logic [NOUT-1:0]    out_d;

`ifdef SCAN_BOUNCE_EN
  logic dir_q, dir_d;   // 1 = counting up
  logic up_eff;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = cur_addr;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
`ifdef SCAN_BOUNCE_EN
    dir_d   = dir_q;
    up_eff  = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (!stop) begin
          if (load && mode == MODE_DIRECT) begin
            state_d = DIRECT;
            addr_d  = address;
          end else if (start && mode == MODE_SCAN) begin
            state_d = SCAN;
            addr_d  = address;
            cnt_d   = dwell;
            dwell_d = dwell;
`ifdef SCAN_BOUNCE_EN
            dir_d   = 1'b1;
`endif
          end
        end
      end
      DIRECT: begin
        if (stop)      state_d = IDLE;
        else if (load) addr_d  = address;
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (enable) begin
          if (cnt_q == '0) begin
            cnt_d = dwell_q;
`ifdef SCAN_BOUNCE_EN
            // A scan started at an end point must step away from it first.
            up_eff = dir_q ? (cur_addr != ADDR_MAX) : (cur_addr == '0);
            if (up_eff) begin
              addr_d = cur_addr + 1'b1;
              wrap_d = (addr_d == ADDR_MAX);
              dir_d  = !wrap_d;
            end else begin
              addr_d = cur_addr - 1'b1;
              wrap_d = (addr_d == '0);
              dir_d  = wrap_d;
            end
`else
            addr_d = cur_addr + 1'b1;
            wrap_d = (cur_addr == ADDR_MAX);
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  onehot_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr   (addr_d),
    .en     (enable && (state_d != IDLE)),
    .onehot (out_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_addr <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      out      <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_addr <= addr_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      out      <= out_d;
      busy     <= (state_d == SCAN);
      wrap     <= wrap_d;
    end
  end

`ifdef SCAN_BOUNCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b1;
    else        dir_q <= dir_d;
  end
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (ADDR_W=2 with per-cycle model, plus an ADDR_W=3 instance).
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 unit after the rising edge.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1, mode = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] address = '0;
  logic [3:0] dwell = '0;
  logic [3:0] out;
  logic [1:0] cur_addr;
  logic       busy, wrap;

  logic       b_enable = 1'b1, b_mode = 1'b0, b_load = 1'b0, b_start = 1'b0, b_stop = 1'b0;
  logic [2:0] b_address = '0;
  logic [3:0] b_dwell = '0;
  logic [7:0] b_out;
  logic [2:0] b_cur_addr;
  logic       b_busy, b_wrap;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  scan_decoder #(.ADDR_W(2), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .address(address),
    .load(load), .start(start), .stop(stop), .dwell(dwell),
    .out(out), .cur_addr(cur_addr), .busy(busy), .wrap(wrap)
  );

  scan_decoder #(.ADDR_W(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .mode(b_mode), .address(b_address),
    .load(b_load), .start(b_start), .stop(b_stop), .dwell(b_dwell),
    .out(b_out), .cur_addr(b_cur_addr), .busy(b_busy), .wrap(b_wrap)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scan position after k steps from index 0 of the walk.
  function automatic int scan_pos(input int k);
    int i;
`ifdef SCAN_BOUNCE_EN
    i = k % 6;
    return (i <= 3) ? i : 6 - i;
`else
    i = k % 4;
    return i;
`endif
  endfunction

  function automatic bit scan_wrap_at(input int p);
`ifdef SCAN_BOUNCE_EN
    return (p == 0) || (p == 3);
`else
    return (p == 0);
`endif
  endfunction

  // Model: scan position derived from the count of enabled cycles since start.
  int m_st, m_addr, m_base, m_ticks, m_dw;
  bit m_en, m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_addr = 0; m_base = 0; m_ticks = 0; m_dw = 0; m_en = 1'b0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      m_en   = enable;
      case (m_st)
        0: begin
          if (!stop && load && mode == 1'b0) begin
            m_st = 1; m_addr = address;
          end else if (!stop && start && mode == 1'b1) begin
            m_st = 2; m_addr = address; m_base = address; m_ticks = 0; m_dw = dwell;
          end
        end
        1: begin
          if (stop) m_st = 0;
          else if (load) m_addr = address;
        end
        default: begin
          if (stop) begin
            m_st = 0;
          end else if (enable) begin
            m_ticks = m_ticks + 1;
            if (m_ticks % (m_dw + 1) == 0) begin
              m_addr = scan_pos(m_base + m_ticks / (m_dw + 1));
              m_wrap = scan_wrap_at(m_addr);
            end
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && cmp_on) begin
      chk("model_out", out, (m_st != 0 && m_en) ? (1 << m_addr) : 0);
      chk("model_cur_addr", cur_addr, m_addr);
      chk("model_busy", busy, (m_st == 2) ? 1 : 0);
      chk("model_wrap", wrap, m_wrap ? 1 : 0);
    end
  end

  int seq3_out[7]  = '{4, 4, 8, 8, 1, 1, 2};
  int seq3_wrap[7] = '{0, 0, 0, 0, 1, 0, 0};
  int seq5_cur[8];
  int seq5_wrap[8];

  initial begin
`ifdef SCAN_BOUNCE_EN
    seq5_cur  = '{0, 1, 2, 3, 2, 1, 0, 1};
    seq5_wrap = '{0, 0, 0, 1, 0, 0, 1, 0};
`else
    seq5_cur  = '{0, 1, 2, 3, 0, 1, 2, 3};
    seq5_wrap = '{0, 0, 0, 0, 1, 0, 0, 0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_cur_addr", cur_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // Direct load, enable blanking
    mode = 1'b0; load = 1'b1; address = 2'd3;
    @(negedge clk); load = 1'b0;
    chk("direct_out", out, 8);
    chk("direct_cur_addr", cur_addr, 3);
    enable = 1'b0;
    @(negedge clk);
    chk("direct_disabled_out", out, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("direct_reenabled_out", out, 8);
    // start and mode change in DIRECT are ignored
    mode = 1'b1; start = 1'b1; address = 2'd1;
    @(negedge clk); start = 1'b0;
    chk("direct_start_ignored_busy", busy, 0);
    chk("direct_start_ignored_addr", cur_addr, 3);
    load = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("direct_reload_out", out, 2);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("direct_stop_out", out, 0);
    chk("direct_stop_keeps_addr", cur_addr, 1);

    // Scan from 2 with dwell 1
    mode = 1'b1; start = 1'b1; address = 2'd2; dwell = 4'd1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("scan_seq_out", out, seq3_out[i]);
      chk("scan_seq_wrap", wrap, seq3_wrap[i]);
      chk("scan_seq_busy", busy, 1);
      @(negedge clk);
    end

    // Pause for 3 cycles, then resume with the remaining dwell
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pause_out", out, 0);
      chk("pause_cur_addr", cur_addr, 1);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("resume_out", out, 4);
    stop = 1'b1; start = 1'b1;
    @(negedge clk); stop = 1'b0; start = 1'b0;
    chk("stop_start_out", out, 0);
    chk("stop_start_busy", busy, 0);
    chk("stop_start_keeps_addr", cur_addr, 2);

    // stop in IDLE beats start
    stop = 1'b1; start = 1'b1; address = 2'd0;
    @(negedge clk); stop = 1'b0; start = 1'b0;
    chk("idle_stop_wins_busy", busy, 0);

    // Asynchronous reset mid-scan
    start = 1'b1; address = 2'd2; dwell = 4'd3;
    @(negedge clk); start = 1'b0;
    chk("prereset_cur_addr", cur_addr, 2);
    chk("prereset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cur_addr", cur_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // dwell 0 scan from 0
    mode = 1'b1; start = 1'b1; address = 2'd0; dwell = 4'd0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("dwell0_cur_addr", cur_addr, seq5_cur[i]);
      chk("dwell0_wrap", wrap, seq5_wrap[i]);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    // ADDR_W=3 instance: first advance from 7 wraps to 0
    b_mode = 1'b1; b_start = 1'b1; b_address = 3'd7; b_dwell = 4'd0;
    @(negedge clk); b_start = 1'b0;
    chk("w3_start_out", b_out, 128);
    chk("w3_start_cur_addr", b_cur_addr, 7);
    @(negedge clk);
    chk("w3_wrap_out", b_out, 1);
    chk("w3_wrap", b_wrap, 1);
    chk("w3_wrap_cur_addr", b_cur_addr, 0);
    b_stop = 1'b1;
    @(negedge clk); b_stop = 1'b0;
    chk("w3_stop_out", b_out, 0);
    chk("w3_stop_busy", b_busy, 0);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
